// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM: memory request, kill-on-redirect, registered output hold.
// Optional FETCH_MISALIGN_EN: misaligned fetch pc reports a fault record and parks in STALL.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        output_valid,
    input  logic        output_ready,
    output logic [63:0] output_data,
    output logic        output_misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_STALL} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_kill, w_kill_nxt;
    logic        r_mem_valid, w_mem_valid_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [63:0] r_out_data, w_out_data_nxt;
    logic        r_out_mis, w_out_mis_nxt;
    logic [31:0] w_redir_pc;
    logic [31:0] w_issue_pc;
    logic        w_xfer;

`ifdef FETCH_MISALIGN_EN
    assign w_redir_pc = redirect_pc;
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^redirect_pc[1:0];
    assign w_redir_pc    = {redirect_pc[31:2], 2'b00};
`endif

    assign w_issue_pc = redirect_valid ? w_redir_pc : r_pc;
    assign w_xfer     = r_out_valid && output_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_data  <= 64'h0;
            r_out_mis   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_kill      <= w_kill_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_mis   <= w_out_mis_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_kill_nxt      = r_kill;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_addr_nxt  = r_mem_addr;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_mis_nxt   = r_out_mis;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = w_issue_pc;
`ifdef FETCH_MISALIGN_EN
                if (w_issue_pc[1:0] != 2'b00) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = {w_issue_pc, 32'h0};
                    w_out_mis_nxt   = 1'b1;
                    w_state_nxt     = S_HOLD;
                end else
`endif
                begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_addr_nxt  = w_issue_pc;
                    w_state_nxt     = S_WAIT;
                end
            end
            S_WAIT: begin
                // While killed, r_pc already holds the redirect target; the request itself stays up.
                if (mem_ready) begin
                    w_mem_valid_nxt = 1'b0;
                    w_kill_nxt      = 1'b0;
                    if (r_kill || redirect_valid) begin
                        if (redirect_valid) begin
                            w_pc_nxt = w_redir_pc;
                        end
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = {r_pc, mem_rdata};
                        w_out_mis_nxt   = 1'b0;
                        w_pc_nxt        = r_pc + 32'd4;
                        w_state_nxt     = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    w_kill_nxt = 1'b1;
                    w_pc_nxt   = w_redir_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_mis_nxt   = 1'b0;
                    w_pc_nxt        = w_redir_pc;
                    w_state_nxt     = S_IDLE;
                end else if (w_xfer) begin
                    w_out_valid_nxt = 1'b0;
                    w_out_mis_nxt   = 1'b0;
                    if (r_out_mis) begin
                        w_state_nxt = S_STALL;
                    end else begin
                        w_mem_valid_nxt = 1'b1;
                        w_mem_addr_nxt  = r_pc;
                        w_state_nxt     = S_WAIT;
                    end
                end
            end
            S_STALL: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_redir_pc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_valid         = r_mem_valid;
    assign mem_addr          = r_mem_addr;
    assign output_valid      = r_out_valid;
    assign output_data       = r_out_data;
    assign output_misaligned = r_out_mis;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed sequences, vector table, random scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        output_valid;
    logic        output_ready;
    logic [63:0] output_data;
    logic        output_misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_addr         (mem_addr),
        .mem_rdata        (mem_rdata),
        .output_valid     (output_valid),
        .output_ready     (output_ready),
        .output_data      (output_data),
        .output_misaligned(output_misaligned)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcs [2];
        logic [31:0] exp_pc;
        logic [31:0] tgt;
        int          got;
        int          n_xfer;
        logic        p_reset, p_mv, p_mr, p_ov, p_xfer, p_redir;
        logic [31:0] p_addr;
        logic [63:0] p_data;

        vecs.push_back('{32'h0000_0100, 32'h0000_0100, 32'h0000_0104});
        vecs.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
        vecs.push_back('{32'h1234_5678, 32'h1234_5678, 32'h1234_567C});
`ifndef FETCH_MISALIGN_EN
        vecs.push_back('{32'h0000_0102, 32'h0000_0100, 32'h0000_0104});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000});
`endif

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_ready = 1'b0; output_ready = 1'b0;
        tick(); tick();
        check("reset mem_valid", mem_valid, 0);
        check("reset output_valid", output_valid, 0);
        check("reset misaligned", output_misaligned, 0);
        check("reset mem_addr", mem_addr, 0);

        reset = 1'b0;
        check("first cycle no mem_valid", mem_valid, 0);
        tick();
        check("second cycle mem_valid", mem_valid, 1);

        // Free-running fetch: request on even cycles, output on odd cycles.
        for (int t = 0; t < 6; t++) begin
            mem_ready    = mem_valid;
            output_ready = (t != 5);
            check($sformatf("stream t%0d mem_valid", t), mem_valid, (t % 2 == 0));
            check($sformatf("stream t%0d output_valid", t), output_valid, (t % 2 == 1));
            if (t % 2 == 0)
                check($sformatf("stream t%0d mem_addr", t), mem_addr, 32'(2 * t));
            else
                check($sformatf("stream t%0d data", t), output_data,
                      {32'(2 * (t - 1)), mem_fn(32'(2 * (t - 1)))});
            if (t != 5) tick();
        end

        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d valid", i), output_valid, 1);
            check($sformatf("hold%0d data", i), output_data, {32'h8, mem_fn(32'h8)});
            check($sformatf("hold%0d no mem_valid", i), mem_valid, 0);
        end
        output_ready = 1'b1;
        tick();
        output_ready = 1'b0;
        check("after hold mem_addr", mem_addr, 32'hC);

        // Redirect while waiting, response arrives three cycles later and must be dropped.
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("killed req held", {mem_valid, mem_addr}, {1'b1, 32'hC});
        tick(); tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("dropped response", {output_valid, mem_valid}, 2'b00);
        tick();
        check("refetch addr", {mem_valid, mem_addr}, {1'b1, 32'h100});
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("refetch output", {output_valid, output_data}, {1'b1, 32'h100, mem_fn(32'h100)});

        // Redirect coinciding with an output transfer.
        output_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; output_ready = 1'b0;
        check("xfer+redirect idle", {output_valid, mem_valid}, 2'b00);
        tick();
        check("xfer+redirect addr", {mem_valid, mem_addr}, {1'b1, 32'h200});

        foreach (vecs[k]) begin
            mem_ready = 1'b0; output_ready = 1'b0;
            redirect_valid = 1'b1; redirect_pc = vecs[k].tgt;
            tick();
            redirect_valid = 1'b0;
            got = 0;
            for (int c = 0; c < 30 && got < 2; c++) begin
                mem_ready = mem_valid; output_ready = 1'b1;
                if (output_valid) begin
                    pcs[got] = output_data[63:32];
                    check($sformatf("vec%0d out%0d instr", k, got), output_data[31:0],
                          mem_fn(output_data[63:32]));
                    got++;
                end
                tick();
            end
            check($sformatf("vec%0d outputs seen", k), got, 2);
            if (got == 2) begin
                check($sformatf("vec%0d pc0", k), pcs[0], vecs[k].pc0);
                check($sformatf("vec%0d pc1", k), pcs[1], vecs[k].pc1);
            end
        end

`ifdef FETCH_MISALIGN_EN
        mem_ready = 1'b0; output_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 10 && !output_valid; c++) begin
            mem_ready = mem_valid;
            tick();
        end
        mem_ready = 1'b0;
        check("misalign record", {output_valid, output_misaligned, output_data},
              {2'b11, 32'h102, 32'h0});
        output_ready = 1'b1;
        tick();
        for (int c = 0; c < 6; c++) begin
            check($sformatf("stall%0d quiet", c), {mem_valid, output_valid}, 2'b00);
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 10 && !output_valid; c++) begin
            mem_ready = mem_valid;
            tick();
        end
        check("stall exit output", {output_valid, output_misaligned, output_data[63:32]},
              {2'b10, 32'h100});
        tick();
`endif

        // Random traffic against a transaction-level scoreboard.
        reset = 1'b1; mem_ready = 1'b0; output_ready = 1'b0; redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        exp_pc = 32'h0; n_xfer = 0;
        p_reset = 1'b1; p_mv = 1'b0; p_mr = 1'b0; p_ov = 1'b0; p_xfer = 1'b0; p_redir = 1'b0;
        p_addr = 32'h0; p_data = 64'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!p_reset && p_mv && !p_mr)
                check("req stable", {mem_valid, mem_addr}, {1'b1, p_addr});
            if (!p_reset && p_ov && !p_xfer && !p_redir)
                check("output stable", {output_valid, output_data}, {1'b1, p_data});
            if (mem_valid && output_valid)
                check("req/output exclusive", 1'b1, 1'b0);

            reset          = ($urandom_range(0, 399) == 0);
            mem_ready      = !reset && mem_valid && ($urandom_range(0, 2) != 0);
            output_ready   = !reset && ($urandom_range(0, 1) == 1);
            redirect_valid = !reset && ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
`ifdef FETCH_MISALIGN_EN
            tgt[1:0] = 2'b00;
`endif
            redirect_pc = tgt;

            if (output_valid && output_ready) begin
                check("rand xfer pc", output_data[63:32], exp_pc);
                check("rand xfer instr", output_data[31:0], mem_fn(exp_pc));
                n_xfer++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = {tgt[31:2], 2'b00};
            if (reset) exp_pc = 32'h0;

            p_reset = reset; p_mv = mem_valid; p_mr = mem_ready; p_addr = mem_addr;
            p_ov = output_valid; p_xfer = output_valid && output_ready;
            p_redir = redirect_valid; p_data = output_data;
            tick();
        end
        reset = 1'b0; redirect_valid = 1'b0; mem_ready = 1'b0; output_ready = 1'b0;
        check("rand progress", (n_xfer >= 200), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
REQ-005 redirect_pc  input  32  new fetch address, sampled when redirect_valid=1.
REQ-006 mem_valid  output  1  instruction memory request valid.
REQ-007 mem_ready  input  1  memory response valid; mem_rdata is valid in the same cycle.
REQ-008 mem_addr  output  32  request address, word aligned.
REQ-009 mem_rdata  input  32  instruction word.
REQ-010 output_valid  output  1  fetched-instruction valid towards the downstream skid buffer.
REQ-011 output_ready  input  1  downstream accepts; a transfer occurs when output_valid && output_ready.
REQ-012 output_data  output  64  {pc[31:0], instr[31:0]}.
REQ-013 output_misaligned  output  1  fault marker for output_data; constant 0 unless FETCH_MISALIGN_EN is defined.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, HOLD and STALL; all outputs are registered.
REQ-015 IDLE: next cycle mem_valid<=1, mem_addr<=pc, state<=WAIT; if redirect_valid, use redirect_pc for both pc and mem_addr.
REQ-016 WAIT: mem_valid and mem_addr SHALL be held stable until mem_ready; a request is never withdrawn.
REQ-017 WAIT, mem_ready, no kill pending, no redirect: mem_valid<=0, output_data<={pc,mem_rdata}, output_valid<=1, pc<=pc+4, state<=HOLD.
REQ-018 WAIT, redirect without mem_ready: set kill, pc<=redirect_pc, stay WAIT; a later redirect overwrites pc (latest wins).
REQ-019 WAIT, mem_ready with kill set or with redirect_valid: discard mem_rdata, clear kill, mem_valid<=0, pc<=redirect_pc if redirect_valid, state<=IDLE.
REQ-020 HOLD: output_valid=1 and output_data SHALL stay stable until a transfer or a redirect.
REQ-021 HOLD, transfer, no redirect: output_valid<=0, mem_valid<=1, mem_addr<=pc, state<=WAIT.
REQ-022 HOLD, redirect (with or without a transfer): output_valid<=0, pc<=redirect_pc, state<=IDLE; redirect takes priority.
REQ-023 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 Latency: mem_ready at cycle N -> output_valid at N+1; peak throughput is one instruction per 2 cycles.
REQ-025 STALL: no requests; leave STALL only on redirect (-> IDLE behaviour per REQ-015).

Reset
REQ-026 On reset: state<=IDLE, pc<=RESET_PC, kill<=0, mem_valid<=0, output_valid<=0, output_misaligned<=0, mem_addr<=RESET_PC.
REQ-027 Reset mid-operation SHALL abandon any outstanding request and any held output, with no further output transfer for it.
REQ-028 The first mem_valid SHALL appear in the second cycle after reset deasserts.

Configuration
REQ-029 Macro FETCH_MISALIGN_EN defined: whenever a request would be issued with pc[1:0]!=0, the block SHALL instead enter HOLD with output_data={pc,32'h0} and output_misaligned=1, assert no mem_valid, and go to STALL after the transfer.
REQ-030 Macro FETCH_MISALIGN_EN undefined: redirect_pc[1:0] SHALL be forced to 2'b00 on capture, output_misaligned is tied 0, and STALL is unreachable.

Verification
REQ-031 Reset, RESET_PC=0, memory always ready, output_ready=1 -> output_data pcs 0,4,8 on every second cycle, instr matching memory.
REQ-032 output_ready=0 for 5 cycles while in HOLD -> output_valid and output_data stable for all 5 cycles, no mem_valid.
REQ-033 Redirect to 0x100 while WAIT, mem_ready 3 cycles later -> that response is dropped; the next mem_addr is 0x100 and the next output pc is 0x100.
REQ-034 Redirect to 0x200 in the same cycle as an output transfer -> no fetch of pc+4; the next mem_addr is 0x200.
REQ-035 pc=0xFFFF_FFFC fetched -> the next mem_addr is 0x0000_0000.
REQ-036 Redirect to 0x102: with FETCH_MISALIGN_EN -> output pc 0x102, output_misaligned=1, no mem_valid until the next redirect; without it -> mem_addr 0x100.
